// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier with WIDTH-bit operands and a 2*WIDTH-bit product.
// Supports per-operation signed/unsigned mode, optional early exit, and a level start/done handshake.
module mult_seq_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] out,
  output logic               done,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mult;
  logic [CW-1:0]   count;
  logic            neg;

  logic [WIDTH-1:0] a_mag, b_mag, mult_nxt;
  logic             calc_last;

  // Negating the most negative operand yields 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign a_mag     = (signed_mode && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (signed_mode && B[WIDTH-1]) ? -B : B;
  assign mult_nxt  = mult >> 1;
  assign calc_last = (count == LAST) || (EARLY_EXIT && (mult_nxt == '0));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start)     state_nxt = S_CALC;
      S_CALC: if (calc_last) state_nxt = S_SIGN;
      S_SIGN:                state_nxt = S_DONE;
      S_DONE: if (!start)    state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if ((state == S_CALC) || (state == S_SIGN)) busy = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments; the synchronous reset clears every
  // register, including the datapath, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      count <= '0;
      neg   <= 1'b0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mult  <= b_mag;
            acc   <= '0;
            count <= '0;
            neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          end
        end
        S_CALC: begin
          // Shifting the multiplicand each step is equivalent to adding mcand << count.
          if (mult[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mult  <= mult_nxt;
          count <= count + 1'b1;
        end
        S_SIGN: out <= neg ? -acc : acc;
        default: ;
      endcase
      // Registered one edge after reaching DONE, and dropped on the edge that sees start low.
      done <= (state == S_DONE) && start;
    end
  end

endmodule
